// File: rtl/snn_pkg.sv
// Shared SNN definitions: neuron count, address width, AER transmitter
// state encoding and a popcount helper for the drop counter.
package snn_pkg;

  localparam int unsigned NUM_NEURONS   = 16;
  localparam int unsigned NEURON_ADDR_W = 4;
  localparam int unsigned CNT_SUM_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } aer_tx_state_t;

  // Number of set bits in a spike vector.
  function automatic logic [CNT_SUM_W-1:0] popcount16(input logic [NUM_NEURONS-1:0] v);
    logic [CNT_SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      s = s + CNT_SUM_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter16.sv
// Combinational round-robin arbiter over 16 requests.
// Ports: req    - request vector
//        ptr    - highest-priority index for this search
//        gnt_addr - first set request at or above ptr (wrapping)
//        gnt_valid - any request present
module rr_arbiter16
  import snn_pkg::*;
(
  input  logic [NUM_NEURONS-1:0]   req,
  input  logic [NEURON_ADDR_W-1:0] ptr,
  output logic [NEURON_ADDR_W-1:0] gnt_addr,
  output logic                     gnt_valid
);

  logic [NUM_NEURONS-1:0]   rot;
  logic [NEURON_ADDR_W-1:0] off;

  // Rotate so ptr lands on bit 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    rot = NUM_NEURONS'({req, req} >> ptr);
    off = '0;
    for (int i = int'(NUM_NEURONS) - 1; i >= 0; i--) begin
      if (rot[i]) off = NEURON_ADDR_W'(i);
    end
    gnt_addr  = off + ptr;
    gnt_valid = |req;
  end

endmodule

// File: rtl/aer_event_tx.sv
// Address-event transmitter: captures 16-bit spike vectors into a pending
// register and emits them one address at a time, round-robin, spaced so the
// downstream accumulate controller is idle when each event arrives.
// Ports: clock, reset_n (async active-low)
//        spike_in_valid/spike_in - spike vector strobe and bits
//        dest_busy      - consumer unavailable, holds off new events in IDLE
//        event_addr     - address of the last event sent (registered)
//        event_received - one-cycle event strobe (registered)
//        busy           - combinational: spikes pending or FSM not idle
//        dropped_cnt    - saturating count of spikes merged into pending bits
module aer_event_tx
  import snn_pkg::*;
#(
  parameter int unsigned EVENT_GAP = 18
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     spike_in_valid,
  input  logic [NUM_NEURONS-1:0]   spike_in,
  input  logic                     dest_busy,
  output logic [NEURON_ADDR_W-1:0] event_addr,
  output logic                     event_received,
  output logic                     busy,
  output logic [7:0]               dropped_cnt
);

  localparam int unsigned GAP_W  = $clog2(EVENT_GAP);
  localparam int unsigned DROP_W = 8;

  aer_tx_state_t            state_q, state_d;
  logic [NUM_NEURONS-1:0]   pend_q, pend_d, clr;
  logic [NEURON_ADDR_W-1:0] rr_q, rr_d, addr_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     ev_d;
  logic [DROP_W-1:0]        drop_d;
  logic [DROP_W:0]          drop_sum;
  logic [NEURON_ADDR_W-1:0] gnt_addr;
  logic                     gnt_valid;

  rr_arbiter16 u_arb (
    .req       (pend_q),
    .ptr       (rr_q),
    .gnt_addr  (gnt_addr),
    .gnt_valid (gnt_valid)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    addr_d  = event_addr;
    ev_d    = 1'b0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && !dest_busy) begin
          state_d = SEND;
          addr_d  = gnt_addr;
          ev_d    = 1'b1;
        end
      end
      SEND: begin
        clr     = NUM_NEURONS'(1) << event_addr;
        rr_d    = event_addr + NEURON_ADDR_W'(1);
        gap_d   = GAP_W'(EVENT_GAP - 3);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending update (new spikes win over the clear) and saturating drop count.
  always_comb begin
    pend_d   = pend_q & ~clr;
    drop_sum = (DROP_W+1)'(dropped_cnt);
    if (spike_in_valid) begin
      pend_d   = (pend_q & ~clr) | spike_in;
      drop_sum = drop_sum + (DROP_W+1)'(popcount16(spike_in & pend_q & ~clr));
    end
    drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pend_q         <= '0;
      rr_q           <= '0;
      gap_q          <= '0;
      event_addr     <= '0;
      event_received <= 1'b0;
      dropped_cnt    <= '0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      rr_q           <= rr_d;
      gap_q          <= gap_d;
      event_addr     <= addr_d;
      event_received <= ev_d;
      dropped_cnt    <= drop_d;
    end
  end

  assign busy = (|pend_q) || (state_q != IDLE);

endmodule

// File: tb/tb_aer_event_tx.sv
// Directed bench for aer_event_tx with an event scoreboard (address + cycle).
module tb_aer_event_tx;

  localparam int EG = 18;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        spike_in_valid = 1'b0;
  logic [15:0] spike_in = '0;
  logic        dest_busy = 1'b0;
  logic [3:0]  event_addr;
  logic        event_received;
  logic        busy;
  logic [7:0]  dropped_cnt;

  aer_event_tx #(.EVENT_GAP(EG)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .spike_in_valid (spike_in_valid),
    .spike_in       (spike_in),
    .dest_busy      (dest_busy),
    .event_addr     (event_addr),
    .event_received (event_received),
    .busy           (busy),
    .dropped_cnt    (dropped_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] addr;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic expect_ev(input int a, input int at);
    exp_t e;
    e.addr = 4'(a);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Compare every event pulse against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && event_received) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event_addr", int'(event_addr), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_addr", int'(event_addr), int'(e.addr));
        check("event_cycle", cyc, e.at);
      end
    end
  end

  // Advance one cycle, driving the inputs for that cycle.
  task automatic step(input logic v, input logic [15:0] s);
    @(posedge clock);
    #1;
    spike_in_valid = v;
    spike_in       = s;
  endtask

  task automatic idle_to(input int t);
    while (cyc < t) step(1'b0, 16'h0);
  endtask

  // Bounded wait for the scoreboard to drain and the block to go idle.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 600) begin
      step(1'b0, 16'h0);
      n++;
    end
    check(tag, exp_q.size() + (busy ? 1000 : 0), 0);
  endtask

  int c0;

  initial begin
    // Reset held for 3 cycles, then quiet for 100 cycles.
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    @(negedge clock);
    check("rst_addr", int'(event_addr), 0);
    check("rst_evt", int'(event_received), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(dropped_cnt), 0);
    step(1'b0, 16'h0);
    reset_n = 1'b1;
    idle_to(cyc + 100);
    @(negedge clock);
    check("quiet_busy", int'(busy), 0);

    // Single spike on neuron 5.
    step(1'b1, 16'h0020);
    c0 = cyc;
    expect_ev(5, c0 + 2);
    step(1'b0, 16'h0);
    @(negedge clock);
    check("single_busy_c1", int'(busy), 1);
    idle_to(c0 + EG + 1);
    @(negedge clock);
    check("single_busy_idle", int'(busy), 0);
    check("single_addr_hold", int'(event_addr), 5);
    drain("single_drain");

    // Full vector: rr is 6 after the last send, so the order starts at 6.
    step(1'b1, 16'hFFFF);
    c0 = cyc;
    for (int i = 0; i < 16; i++) expect_ev((6 + i) % 16, c0 + 2 + i * EG);
    drain("full_drain");

    // Reset to bring rr back to 0 for the wrap sequence.
    reset_n = 1'b0;
    step(1'b0, 16'h0);
    reset_n = 1'b1;

    // Round-robin wrap: 0 then 15, then 0 and 1 without re-granting 15.
    step(1'b1, 16'h8001);
    c0 = cyc;
    expect_ev(0, c0 + 2);
    expect_ev(15, c0 + 2 + EG);
    idle_to(c0 + 2 + EG);
    step(1'b1, 16'h0003);
    expect_ev(0, c0 + 2 + 2 * EG);
    expect_ev(1, c0 + 2 + 3 * EG);
    drain("wrap_drain");

    // dest_busy holds off the grant for 40 cycles.
    dest_busy = 1'b1;
    step(1'b1, 16'h0004);
    c0 = cyc;
    idle_to(c0 + 20);
    @(negedge clock);
    check("hold_busy", int'(busy), 1);
    idle_to(c0 + 39);
    step(1'b0, 16'h0);
    dest_busy = 1'b0;
    expect_ev(2, c0 + 41);
    drain("hold_drain");

    // Re-inject bit 0 during its own SEND cycle: second event one gap later.
    step(1'b1, 16'h0001);
    c0 = cyc;
    expect_ev(0, c0 + 2);
    expect_ev(0, c0 + 2 + EG);
    step(1'b0, 16'h0);
    step(1'b1, 16'h0001);
    drain("reinject_drain");
    check("reinject_drop", int'(dropped_cnt), 0);

    // Second spike on an already pending bit is merged and counted.
    step(1'b1, 16'h0002);
    c0 = cyc;
    expect_ev(1, c0 + 2);
    step(1'b1, 16'h0002);
    step(1'b0, 16'h0);
    @(negedge clock);
    check("drop_cnt", int'(dropped_cnt), 1);
    drain("drop_drain");

    // Async reset in GAP discards the in-flight and pending work.
    step(1'b1, 16'h0300);
    c0 = cyc;
    expect_ev(8, c0 + 2);
    idle_to(c0 + 5);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_drop", int'(dropped_cnt), 0);
    check("arst_addr", int'(event_addr), 0);
    step(1'b0, 16'h0);
    reset_n = 1'b1;
    idle_to(cyc + 60);
    @(negedge clock);
    check("arst_quiet_busy", int'(busy), 0);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
